lab3_qsys_mem_tester: RTL

//  Avalon-MM master that drives the single-port on-chip RAM slave (s1 side) for bring-up/self-test.

---
 rtl/lab3_qsys_mem_tester_if.sv | 39 +++
 rtl/lab3_qsys_mem_tester.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lab3_qsys_mem_tester_if.sv
// Avalon-MM bus between the memory tester (master) and the single-port
// on-chip RAM s1 port (slave).
//
// Transfer semantics: an access happens in every cycle where chipselect is
// high; write selects a write (writedata/byteenable used) versus a read.
// There is no waitrequest, so the slave accepts every access at the clock
// edge that ends the cycle. Read data appears on readdata in the cycle
// immediately after the read was issued and is not otherwise qualified.
//
// Signals:
//   address    master->slave  word address
//   chipselect master->slave  access strobe
//   write      master->slave  1 = write, 0 = read (only meaningful with chipselect)
//   byteenable master->slave  byte lanes, held at all ones
//   writedata  master->slave  write data
//   clken      master->slave  slave clock enable, held at 1
//   readdata   slave->master  read data, one cycle after read issue
interface lab3_qsys_mem_tester_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write, byteenable, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, byteenable, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/lab3_qsys_mem_tester.sv
// Self-test master for the lab3_qsys on-chip RAM. A fill command writes
// seed+i to each word of an address window; a verify command reads the
// window back and counts words that differ from seed+i.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   start             1-cycle command pulse, accepted only while idle
//   mode              0 = fill, 1 = verify (sampled on start)
//   base_addr         first word address (sampled on start, reduced mod MEM_DEPTH)
//   length            word count (sampled on start, clamped to MEM_DEPTH)
//   seed              pattern seed (sampled on start)
//   abort             stop issuing accesses; in-flight read still compared
//   m                 Avalon-MM master port to the RAM slave
//   busy              command in progress
//   done              1-cycle pulse at the end of every accepted command
//   aborted           last command was ended by abort
//   err_count         saturating verify mismatch count
//   first_err_addr    address of the first mismatch of the command
//   state_dbg         current FSM state
module lab3_qsys_mem_tester #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 15000,
    parameter int ERRCNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    input  logic                abort,
    lab3_qsys_mem_tester_if.master m,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W+1)'(1);

    logic [1:0]          state_q;
    logic                mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W:0]     cnt_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   rd_exp_q;
    logic [ADDR_W-1:0]   rd_addr_q;

    logic [ADDR_W-1:0]   base_sel;
    logic [ADDR_W:0]     len_sel;
    logic [ADDR_W-1:0]   addr_next;
    logic                run;

    // 2**ADDR_W < 2*MEM_DEPTH, so one conditional subtract brings any
    // base address into range.
    assign base_sel  = ({1'b0, base_addr} >= DEPTH_L) ? (base_addr - DEPTH_L[ADDR_W-1:0]) : base_addr;
    assign len_sel   = (length > DEPTH_L) ? DEPTH_L : length;
    assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign run       = (state_q == S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            cnt_q          <= '0;
            rd_pend_q      <= 1'b0;
            rd_exp_q       <= '0;
            rd_addr_q      <= '0;
            aborted        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q         <= mode;
                        addr_q         <= base_sel;
                        data_q         <= seed;
                        cnt_q          <= len_sel;
                        aborted        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        state_q        <= (length == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // The access on the bus this cycle always completes;
                    // abort only prevents the next one.
                    addr_q <= addr_next;
                    data_q <= data_q + 1'b1;
                    cnt_q  <= cnt_q - 1'b1;
                    if (abort || (cnt_q == ONE_L)) begin
                        state_q <= S_DRAIN;
                    end
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                S_DRAIN: state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase

            // Read data returns one cycle after issue, so the expected word
            // and its address travel one stage behind the bus.
            rd_pend_q <= run && mode_q;
            rd_exp_q  <= data_q;
            rd_addr_q <= addr_q;

            // rd_pend_q is never set in IDLE, so this cannot collide with
            // the clear on start.
            if (rd_pend_q && (m.readdata != rd_exp_q)) begin
                if (err_count == '0) begin
                    first_err_addr <= rd_addr_q;
                end
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    assign m.chipselect = run;
    assign m.write      = run && !mode_q;
    assign m.address    = run ? addr_q : '0;
    assign m.writedata  = (run && !mode_q) ? data_q : '0;
    assign m.byteenable = 4'hF;
    assign m.clken      = 1'b1;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;
endmodule
